// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder: valid/ready word intake, one-word holding buffer,
// LSB-first serial replay. Define SERIAL_FEEDER_FLUSH_EN to append FLUSH_BITS zeros per word.
module serial_word_feeder #(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned FLUSH_BITS  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INPUT_WIDTH-1:0] word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic                   bit_first,
  output logic                   bit_last,
  output logic                   bit_flush,
  output logic                   busy,
  output logic [7:0]             words_sent
);

  localparam int unsigned IDX_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SERIAL_FEEDER_FLUSH_EN
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [3:0] LAST_FC  = 4'(FLUSH_BITS - 1);
`endif

  if (INPUT_WIDTH < 2 || INPUT_WIDTH > 32 || FLUSH_BITS < 1 || FLUSH_BITS > 15) begin : g_param_check
    $error("serial_word_feeder: INPUT_WIDTH or FLUSH_BITS out of range");
  end

  logic [1:0]             r_state;
  logic [INPUT_WIDTH-1:0] r_buf;
  logic                   r_buf_full;
  logic [INPUT_WIDTH-1:0] r_sh;
  logic [IDX_W-1:0]       r_idx;
  logic [7:0]             r_words_sent;
`ifdef SERIAL_FEEDER_FLUSH_EN
  logic [3:0]             r_fcnt;
`endif

  logic w_shift;
  logic w_last_bit;
  logic w_flush;

  always_comb begin
    w_shift    = (r_state == ST_SHIFT);
    w_last_bit = w_shift && (r_idx == LAST_IDX);
`ifdef SERIAL_FEEDER_FLUSH_EN
    w_flush    = (r_state == ST_FLUSH);
`else
    w_flush    = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_buf        <= '0;
      r_buf_full   <= 1'b0;
      r_sh         <= '0;
      r_idx        <= '0;
      r_words_sent <= '0;
`ifdef SERIAL_FEEDER_FLUSH_EN
      r_fcnt       <= '0;
`endif
    end else begin
      // Intake only when empty and reload only when full, so these never touch r_buf_full together.
      if (word_valid && !r_buf_full) begin
        r_buf      <= word_in;
        r_buf_full <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_buf_full) begin
            r_sh       <= r_buf;
            r_buf_full <= 1'b0;
            r_idx      <= '0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sh  <= r_sh >> 1;
          r_idx <= r_idx + IDX_W'(1);
          if (w_last_bit) begin
            r_words_sent <= r_words_sent + 8'd1;
`ifdef SERIAL_FEEDER_FLUSH_EN
            r_fcnt  <= '0;
            r_state <= ST_FLUSH;
`else
            if (r_buf_full) begin
              r_sh       <= r_buf;
              r_buf_full <= 1'b0;
              r_idx      <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
`endif
          end
        end
`ifdef SERIAL_FEEDER_FLUSH_EN
        ST_FLUSH: begin
          r_fcnt <= r_fcnt + 4'd1;
          if (r_fcnt == LAST_FC) begin
            if (r_buf_full) begin
              r_sh       <= r_buf;
              r_buf_full <= 1'b0;
              r_idx      <= '0;
              r_state    <= ST_SHIFT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    word_ready = !r_buf_full;
    bit_valid  = (r_state != ST_IDLE);
    bit_out    = w_shift && r_sh[0];
    bit_first  = w_shift && (r_idx == '0);
    bit_last   = w_last_bit;
    bit_flush  = w_flush;
    busy       = (r_state != ST_IDLE) || r_buf_full;
    words_sent = r_words_sent;
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder: stimulus pushes expected serial bits, a negedge monitor pops and compares.
module tb_serial_word_feeder;

  localparam int W  = 8;
  localparam int FB = 3;
`ifdef SERIAL_FEEDER_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif
  localparam int PERIOD = FLUSH_ON ? (W + FB) : W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_ready, bit_out, bit_valid, bit_first, bit_last, bit_flush, busy;
  logic [7:0]   words_sent;

  serial_word_feeder #(.INPUT_WIDTH(W), .FLUSH_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_first(bit_first), .bit_last(bit_last), .bit_flush(bit_flush),
    .busy(busy), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic b; logic f; logic l; logic fl;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int exp_sent = 0;
  int run_len = 0;
  int max_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every valid serial bit with the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bit_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit actual=%b required=no_bit at %0t", bit_out, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("bit_out",   bit_out,   e.b);
          chk("bit_first", bit_first, e.f);
          chk("bit_last",  bit_last,  e.l);
          chk("bit_flush", bit_flush, e.fl);
        end
      end else begin
        run_len = 0;
        chk("idle_zero", {bit_out, bit_first, bit_last, bit_flush}, 4'b0000);
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) q.push_back('{b: w[i], f: (i == 0), l: (i == W-1), fl: 1'b0});
    if (FLUSH_ON) for (int i = 0; i < FB; i++) q.push_back('{b: 1'b0, f: 1'b0, l: 1'b0, fl: 1'b1});
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] w, input bit junk, input bit hold);
    int n;
    n = 0;
    word_valid = 1'b1;
    word_in = junk ? W'($urandom) : w;
    while (!word_ready && n < 100) begin
      @(negedge clk);
      if (junk) word_in = W'($urandom);
      n++;
    end
    if (!word_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      word_valid = 1'b0;
      return;
    end
    word_in = w;
    @(posedge clk);
    push_word(w);
    exp_sent++;
    @(negedge clk);
    if (junk) word_in = W'($urandom);
    if (!hold) word_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || bit_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, busy, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_ready", word_ready, 1'b1);
    chk("rst_outs", {bit_out, bit_valid, bit_first, bit_last, bit_flush, busy}, 6'b0);
    chk("rst_sent", words_sent, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word 0x5A: latency and LSB-first order
    max_run = 0;
    send(8'b0101_1010, 1'b0, 1'b0);
    chk("lat_edge_n", bit_valid, 1'b0);
    @(negedge clk);
    chk("lat_first_valid", {bit_valid, bit_first, bit_out}, 3'b110);
    wait_idle("single");
    chk("single_run", max_run, PERIOD);
    chk("single_sent", words_sent, 8'd1);

    // Back-to-back 0xA5, 0x3C with valid held
    max_run = 0;
    send(8'hA5, 1'b0, 1'b1);
    send(8'h3C, 1'b0, 1'b1);
    chk("ready_low_full", word_ready, 1'b0);
    chk("busy_full", busy, 1'b1);
    word_valid = 1'b0;
    wait_idle("b2b");
    chk("b2b_run", max_run, 2 * PERIOD);
    chk("b2b_sent", words_sent, 8'd3);

    // 0xFF then 0x00 (flush period visible when compiled in)
    max_run = 0;
    send(8'hFF, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    wait_idle("ff00");
    chk("ff00_run", max_run, 2 * PERIOD);
    chk("ff00_sent", words_sent, 8'd5);

    // Backpressure: junk on word_in while not ready
    send(8'hC3, 1'b0, 1'b1);
    send(8'h96, 1'b1, 1'b1);
    send(8'h3E, 1'b1, 1'b0);
    wait_idle("bp");
    chk("bp_sent", words_sent, 8'd8);

    // Reset mid-SHIFT with the buffer full
    send(8'h77, 1'b0, 1'b1);
    send(8'h11, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bit_valid, 1'b0);
    chk("mid_rst_ready", word_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sent", words_sent, 8'd0);
    q.delete();
    exp_sent = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", bit_valid, 1'b0);

    // Counter wrap
    for (int i = 0; i < 255; i++) send(W'(i), 1'b0, 1'b1);
    word_valid = 1'b0;
    wait_idle("wrap255");
    chk("wrap_255", words_sent, 8'd255);
    send(8'hE7, 1'b0, 1'b0);
    wait_idle("wrap256");
    chk("wrap_0", words_sent, 8'd0);
    chk("model_count", exp_sent, 256);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
